dac_interleaver: RTL

Parametrised successor to the fixed 14-bit two-channel DAC splitter. It accepts two signed sample streams wider than the DAC, then saturates and formats each one (two's complement or offset binary). It hold-fills missing samples and presents per-edge DDR words (D1/D2) for channels B/A plus the select and reset lines. A startup sequencer handles the DAC reset/warm-up. Sits between the lockbox servo outputs and the ODDR bank driving the dual-channel interleaved DAC.

---
 rtl/lockbox_dac_pkg.sv | 37 +++
 rtl/dac_interleaver_if.sv | 26 ++
 rtl/dac_sat_fmt.sv | 73 +++++++
 rtl/dac_interleaver.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/lockbox_dac_pkg.sv
// Purpose : shared types and helpers for the interleaved-DAC front end
//           (startup state encoding, zero-code and saturation helpers).
// Contents: dac_state_e, MAX_W, zero_code(), saturate().
package lockbox_dac_pkg;

   // Startup sequencer states.
   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } dac_state_e;

   // Helpers work on a fixed wide container; callers cast down to their width.
   localparam int MAX_W = 64;

   // Mid-scale code: all zeros in two's complement, MSB-only in offset binary.
   function automatic logic [MAX_W-1:0] zero_code(input int width, input logic fmt);
      logic [MAX_W-1:0] v;
      v = '0;
      if (fmt) v[width-1] = 1'b1;
      return v;
   endfunction

   // Clamp a sign-extended value into the signed range of out_w bits.
   // The caller detects clipping by comparing the result with the input.
   function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] x,
                                                        input int out_w);
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

endpackage

// File: rtl/dac_interleaver_if.sv
// Purpose : sample-in / DDR-word-out bundle of the interleaved-DAC front end.
// Ports   : din_a/din_b + valids from the servo; dout_d1/dout_d2 + sel_d1/sel_d2
//           towards the ODDR bank. master = sample source / DAC side, slave = DUT.
interface dac_interleaver_if #(
   parameter int DATA_WIDTH = 14,
   parameter int IN_WIDTH   = 16
);
   logic signed [IN_WIDTH-1:0]   din_a;
   logic                         din_a_valid;
   logic signed [IN_WIDTH-1:0]   din_b;
   logic                         din_b_valid;
   logic        [DATA_WIDTH-1:0] dout_d1;
   logic        [DATA_WIDTH-1:0] dout_d2;
   logic                         sel_d1;
   logic                         sel_d2;

   modport master (
      output din_a, din_a_valid, din_b, din_b_valid,
      input  dout_d1, dout_d2, sel_d1, sel_d2
   );

   modport slave (
      input  din_a, din_a_valid, din_b, din_b_valid,
      output dout_d1, dout_d2, sel_d1, sel_d2
   );
endinterface

// File: rtl/dac_sat_fmt.sv
// Purpose : one DAC channel: hold-fill stage 1, saturate/format stage 2, sticky clip flag.
// Latency : 2 cycles sample-in to o_dout; no backpressure, a missing sample repeats the last one.
// Ports   : clk/rst_n; i_clr (drop hold), i_run/i_run_nxt (sequencer), i_din/i_valid,
//           i_en/i_fmt/i_sat_clr controls; o_dout word, o_sat flag, o_underrun strobe.
module dac_sat_fmt
   import lockbox_dac_pkg::*;
#(
   parameter int DATA_WIDTH = 14,
   parameter int IN_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_clr,
   input  logic                         i_run,
   input  logic                         i_run_nxt,
   input  logic signed [IN_WIDTH-1:0]   i_din,
   input  logic                         i_valid,
   input  logic                         i_en,
   input  logic                         i_fmt,
   input  logic                         i_sat_clr,
   output logic        [DATA_WIDTH-1:0] o_dout,
   output logic                         o_sat,
   output logic                         o_underrun
);

   // Stage 1 doubles as the hold register: it only loads on an accepted sample.
   logic signed [IN_WIDTH-1:0]   r_hold;
   logic        [DATA_WIDTH-1:0] r_dout;
   logic                         r_sat;

   logic signed [MAX_W-1:0]      w_sext;
   logic signed [MAX_W-1:0]      w_satv;
   logic                         w_clip;
   logic        [DATA_WIDTH-1:0] w_zero;
   logic        [DATA_WIDTH-1:0] w_word;
   logic        [DATA_WIDTH-1:0] w_dout_nxt;
   logic                         w_sat_set;

   assign w_sext = MAX_W'(r_hold);
   assign w_satv = saturate(w_sext, DATA_WIDTH);
   assign w_clip = (w_satv != w_sext);
   assign w_zero = DATA_WIDTH'(zero_code(DATA_WIDTH, i_fmt));
   // Offset binary is two's complement with the MSB flipped.
   assign w_word = DATA_WIDTH'(w_satv) ^ {i_fmt, {(DATA_WIDTH-1){1'b0}}};

   // Stage 2 is gated by the next state so the word registered on the edge that
   // leaves RUN (restart) is already the zero code.
   always_comb begin
      w_dout_nxt = w_zero;
      if (i_run_nxt && i_en) w_dout_nxt = w_word;
   end

   assign w_sat_set  = i_run_nxt & i_en & w_clip;
   assign o_underrun = i_run & i_en & ~i_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
         r_dout <= '0;
         r_sat  <= 1'b0;
      end else begin
         if (i_clr)                r_hold <= '0;
         else if (i_run && i_valid) r_hold <= i_din;
         r_dout <= w_dout_nxt;
         // A new clip in the same cycle as the clear keeps the flag set.
         r_sat  <= w_sat_set | (r_sat & ~i_sat_clr);
      end
   end

   assign o_dout = r_dout;
   assign o_sat  = r_sat;

endmodule

// File: rtl/dac_interleaver.sv
// Purpose : dual-channel DAC front end: startup sequencer, per-channel saturate/format, DDR words.
// Latency : 2 cycles sample-in to dout_d1 (B) / dout_d2 (A); no backpressure, gaps are hold-filled.
// Ports   : clk, rst_n, restart, fmt_offset_bin, ch_en, sat_clr; dac_if (samples in, D1/D2 + sel out);
//           dac_rst_o, running, sat_flags, underrun_cnt status.
module dac_interleaver
   import lockbox_dac_pkg::*;
#(
   parameter int DATA_WIDTH  = 14,
   parameter int IN_WIDTH    = 16,
   parameter int RST_CYCLES  = 16,
   parameter int WARM_CYCLES = 64,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 restart,
   input  logic                 fmt_offset_bin,
   input  logic [1:0]           ch_en,
   input  logic                 sat_clr,
   dac_interleaver_if.slave     dac_if,
   output logic                 dac_rst_o,
   output logic                 running,
   output logic [1:0]           sat_flags,
   output logic [CNT_WIDTH-1:0] underrun_cnt
);

   localparam int CMAX = (RST_CYCLES > WARM_CYCLES) ? RST_CYCLES : WARM_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   dac_state_e            r_state;
   dac_state_e            w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  r_dac_rst;
   logic                  r_running;
   logic                  r_sel_d1;
   logic [CNT_WIDTH-1:0]  r_und;

   logic                  w_run;
   logic                  w_run_nxt;
   logic [DATA_WIDTH-1:0] w_dout_a;
   logic [DATA_WIDTH-1:0] w_dout_b;
   logic                  w_sat_a;
   logic                  w_sat_b;
   logic                  w_und_a;
   logic                  w_und_b;
   logic [1:0]            w_und_inc;
   logic [CNT_WIDTH:0]    w_und_sum;

   // ---------------- startup sequencer ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (restart) begin
         w_state_nxt = ST_RESET;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_RESET: begin
               if (r_cnt == CW'(RST_CYCLES - 1)) begin
                  w_state_nxt = ST_WARMUP;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            ST_WARMUP: begin
               if (r_cnt == CW'(WARM_CYCLES - 1)) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            ST_RUN: begin
               w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = ST_RESET;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Status outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RESET;
         r_cnt     <= '0;
         r_dac_rst <= 1'b1;
         r_running <= 1'b0;
         r_sel_d1  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_dac_rst <= (w_state_nxt == ST_RESET);
         r_running <= (w_state_nxt == ST_RUN);
         r_sel_d1  <= 1'b1;
      end
   end

   assign w_run     = (r_state == ST_RUN);
   assign w_run_nxt = (w_state_nxt == ST_RUN);

   // ---------------- channel datapaths ----------------
   dac_sat_fmt #(.DATA_WIDTH(DATA_WIDTH), .IN_WIDTH(IN_WIDTH)) u_ch_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (restart),
      .i_run      (w_run),
      .i_run_nxt  (w_run_nxt),
      .i_din      (dac_if.din_a),
      .i_valid    (dac_if.din_a_valid),
      .i_en       (ch_en[0]),
      .i_fmt      (fmt_offset_bin),
      .i_sat_clr  (sat_clr),
      .o_dout     (w_dout_a),
      .o_sat      (w_sat_a),
      .o_underrun (w_und_a)
   );

   dac_sat_fmt #(.DATA_WIDTH(DATA_WIDTH), .IN_WIDTH(IN_WIDTH)) u_ch_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (restart),
      .i_run      (w_run),
      .i_run_nxt  (w_run_nxt),
      .i_din      (dac_if.din_b),
      .i_valid    (dac_if.din_b_valid),
      .i_en       (ch_en[1]),
      .i_fmt      (fmt_offset_bin),
      .i_sat_clr  (sat_clr),
      .o_dout     (w_dout_b),
      .o_sat      (w_sat_b),
      .o_underrun (w_und_b)
   );

   // ---------------- underrun counter ----------------
   // Both channels missing in one cycle add 2; the extra sum bit flags overflow.
   assign w_und_inc = {1'b0, w_und_a} + {1'b0, w_und_b};
   assign w_und_sum = {1'b0, r_und} + {{(CNT_WIDTH-1){1'b0}}, w_und_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_und <= '0;
      else        r_und <= w_und_sum[CNT_WIDTH] ? '1 : w_und_sum[CNT_WIDTH-1:0];
   end

   // ---------------- outputs ----------------
   // B goes out on the rising edge (D1), A on the falling edge (D2).
   assign dac_if.dout_d1 = w_dout_b;
   assign dac_if.dout_d2 = w_dout_a;
   assign dac_if.sel_d1  = r_sel_d1;
   assign dac_if.sel_d2  = 1'b0;
   assign dac_rst_o      = r_dac_rst;
   assign running        = r_running;
   assign sat_flags      = {w_sat_b, w_sat_a};
   assign underrun_cnt   = r_und;

endmodule
